// File: rtl/div_unit_e.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} with a one-cycle ready pulse.
module div_unit_e #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               annul,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {FREE, ON, BYZERO, END} state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             sign1;
    logic             sign2;
    logic             sgn;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    // The shifted remainder keeps its top bit so large unsigned divisors
    // (MSB set) still compare correctly; dvd doubles as the quotient register.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {dvd[WIDTH-2:0], q_bit};
        quo_fix  = (sgn && (sign1 ^ sign2)) ? -quo_next : quo_next;
        rem_fix  = (sgn && sign1) ? -rem_next : rem_next;
        abs1     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FREE;
            counter <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            sign1   <= 1'b0;
            sign2   <= 1'b0;
            sgn     <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    if (!annul && start) begin
                        busy <= 1'b1;
                        if (opdata2 == '0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            dvd     <= abs1;
                            divisor <= abs2;
                            sign1   <= opdata1[WIDTH-1];
                            sign2   <= opdata2[WIDTH-1];
                            sgn     <= signed_div;
                            counter <= '0;
                            rem     <= '0;
                        end
                    end
                end
                ON: begin
                    if (annul) begin
                        state <= FREE;
                        busy  <= 1'b0;
                    end else begin
                        rem     <= rem_next;
                        dvd     <= quo_next;
                        counter <= counter + CW'(1);
                        if (counter == CW'(WIDTH - 1)) begin
                            state  <= END;
                            busy   <= 1'b0;
                            ready  <= 1'b1;
                            result <= {rem_fix, quo_fix};
                        end
                    end
                end
                BYZERO: begin
                    busy <= 1'b0;
                    if (annul) begin
                        state <= FREE;
                    end else begin
                        state  <= END;
                        ready  <= 1'b1;
                        result <= '0;
                    end
                end
                END: begin
                    state <= FREE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= FREE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_e.sv
// Testbench for div_unit_e: directed corner cases plus random DIV/DIVU
// operations checked against an arithmetic reference model.
module tb_div_unit_e;

    logic        clk;
    logic        reset;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int total  = 0;
    int passed = 0;

    div_unit_e #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain language-level division, with x/0 and INT_MIN/-1 defined.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return 64'h0;
        if (sd) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one operation and waits for ready. exp_lat counts rising edges
    // from the call to the first cycle with ready high. hold leaves start
    // asserted afterwards so the next call forms a back-to-back pair.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input bit hold);
        logic [63:0] expv;
        int cyc;
        expv       = ref_div(sd, a, b);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        cyc        = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == exp_lat - 1) check({tag, " busy"}, 64'(busy), 64'h1);
            if (cyc == 3) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~sd;
            end
        end while (!ready && cyc < 200);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " result"}, result, expv);
        if (!hold) begin
            start = 1'b0;
            @(posedge clk);
            #1;
            check({tag, " ready drop"}, {62'h0, ready, busy}, 64'h0);
        end
    endtask

    initial begin
        int seen;
        logic        rsd;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        reset      = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'h0;
        opdata2    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {result[61:0], ready, busy}, 64'h0);
        check("reset result hi", 64'(result[63:62]), 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 1'b0);
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("div 5/0", 1'b1, 32'd5, 32'd0, 2, 1'b0);
        run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 1'b0);
        run_op("divu big divisor", 1'b0, 32'hFFFF_FFF0, 32'h8000_0001, 33, 1'b0);

        // Annul part-way through the iterations.
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul idle", {62'h0, ready, busy}, 64'h0);
        annul = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("annul no ready", 64'(seen), 64'h0);
        run_op("divu 9/3", 1'b0, 32'd9, 32'd3, 33, 1'b0);

        // start together with annul in FREE never launches an operation.
        start   = 1'b1;
        annul   = 1'b1;
        opdata1 = 32'd50;
        opdata2 = 32'd5;
        seen    = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready || busy) seen++;
        end
        check("start+annul", 64'(seen), 64'h0);
        start = 1'b0;
        annul = 1'b0;

        // Back-to-back with start held: second ready 34 edges after the first.
        run_op("b2b first", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 1'b1);
        run_op("b2b intmin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);

        // Asynchronous reset in the middle of an operation.
        signed_div = 1'b0;
        opdata1    = 32'd12345;
        opdata2    = 32'd17;
        start      = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async reset", {result[61:0], ready, busy}, 64'h0);
        check("async reset hi", 64'(result[63:62]), 64'h0);
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op("divu after reset", 1'b0, 32'd12345, 32'd17, 33, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: rb = $urandom;
            endcase
            lat = (rb == 32'h0) ? 2 : 33;
            run_op($sformatf("rand %0d", i), rsd, ra, rb, lat, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
